i2s_frame_sequencer: RTL and testbench

//  Sequences the I2S DAC path: divides MCLK into SCLK/LRCLK and, once per stereo frame, polls up to
//  NUM_SRC sample sources through a valid/ready handshake. It saturating-sums their L/R samples and

---
 rtl/i2s_pkg.sv | 30 +++
 rtl/i2s_clk_div.sv | 29 ++
 rtl/i2s_frame_sequencer.sv | 149 ++++++++++++++
 tb/tb_i2s_frame_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S frame sequencer: FSM encoding, frame timing constants and
// the commit-time saturation helper.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    NEXT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FRAME_LEN = 256;
  localparam int SCLK_DIV  = 4;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] COMMIT_CNT = CNT_W'(FRAME_LEN - 1);

  // Clamp a sign-extended value into the range of a w-bit two's complement number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    return v;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Free-running frame counter with registered SCLK/LRCLK taps; sclk/lrclk always equal cnt's bits.
// No backpressure: advances every clock, wraps at FRAME_LEN.
module i2s_clk_div import i2s_pkg::*; (
  input  logic             clk,
  input  logic             res_n,
  output logic [CNT_W-1:0] cnt,
  output logic             sclk,
  output logic             lrclk
);

  localparam int SCLK_BIT = $clog2(SCLK_DIV) - 1;

  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt   <= '0;
      sclk  <= 1'b0;
      lrclk <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      sclk  <= cnt_nxt[SCLK_BIT];
      lrclk <= cnt_nxt[CNT_W-1];
    end
  end

endmodule

// File: rtl/i2s_frame_sequencer.sv
// Polls NUM_SRC sources once per frame, saturating-sums them and commits at cnt==255 (valid from cnt==0).
// Each source gets TIMEOUT cycles of src_rdy; macro UNDERRUN_HOLD_EN replays the last pair on timeout.
module i2s_frame_sequencer import i2s_pkg::*; #(
  parameter int bitNum  = 32,
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      MCLK,
  input  logic                      res_n,
  input  logic                      enable,
  input  logic [NUM_SRC-1:0]        src_vld,
  input  logic [NUM_SRC*bitNum-1:0] src_data_l,
  input  logic [NUM_SRC*bitNum-1:0] src_data_r,
  output logic [NUM_SRC-1:0]        src_rdy,
  output logic                      SCLK,
  output logic                      LRCLK,
  output logic [bitNum-1:0]         DATA_L,
  output logic [bitNum-1:0]         DATA_R,
  output logic [NUM_SRC-1:0]        underrun,
  output logic                      frame_tick
);

  localparam int AW = bitNum + 3;
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0]         cnt;
  state_t                   state;
  logic [IW-1:0]            idx;
  logic [WW-1:0]            wcnt;
  logic signed [AW-1:0]     acc_l;
  logic signed [AW-1:0]     acc_r;
  logic signed [bitNum-1:0] cur_l;
  logic signed [bitNum-1:0] cur_r;
  logic signed [bitNum-1:0] fill_l;
  logic signed [bitNum-1:0] fill_r;
  logic                     xfer;

  i2s_clk_div u_clk_div (
    .clk   (MCLK),
    .res_n (res_n),
    .cnt   (cnt),
    .sclk  (SCLK),
    .lrclk (LRCLK)
  );

  always_comb begin
    cur_l = src_data_l[idx*bitNum +: bitNum];
    cur_r = src_data_r[idx*bitNum +: bitNum];
    xfer  = src_vld[idx] & src_rdy[idx];
  end

`ifdef UNDERRUN_HOLD_EN
  logic signed [bitNum-1:0] hold_l [NUM_SRC];
  logic signed [bitNum-1:0] hold_r [NUM_SRC];

  assign fill_l = hold_l[idx];
  assign fill_r = hold_r[idx];

  always_ff @(posedge MCLK) begin
    if (!res_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        hold_l[i] <= '0;
        hold_r[i] <= '0;
      end
    end else if (state == REQ && xfer) begin
      hold_l[idx] <= cur_l;
      hold_r[idx] <= cur_r;
    end
  end
`else
  assign fill_l = '0;
  assign fill_r = '0;
`endif

  always_ff @(posedge MCLK) begin
    if (!res_n) begin
      state    <= IDLE;
      idx      <= '0;
      wcnt     <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      src_rdy  <= '0;
      underrun <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A disabled frame still clears the accumulators so silence is committed.
          if (cnt == '0) begin
            acc_l <= '0;
            acc_r <= '0;
            if (enable) begin
              state   <= REQ;
              idx     <= '0;
              wcnt    <= '0;
              src_rdy <= NUM_SRC'(1);
            end
          end
        end
        REQ: begin
          if (xfer) begin
            acc_l   <= acc_l + AW'(cur_l);
            acc_r   <= acc_r + AW'(cur_r);
            src_rdy <= '0;
            state   <= NEXT;
          end else if (wcnt == WW'(TIMEOUT - 1)) begin
            underrun[idx] <= 1'b1;
            acc_l         <= acc_l + AW'(fill_l);
            acc_r         <= acc_r + AW'(fill_r);
            src_rdy       <= '0;
            state         <= NEXT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        NEXT: begin
          if (idx == IW'(NUM_SRC - 1)) begin
            state <= DONE;
          end else begin
            idx     <= idx + 1'b1;
            wcnt    <= '0;
            src_rdy <= NUM_SRC'(1) << (idx + 1'b1);
            state   <= REQ;
          end
        end
        DONE: begin
          if (cnt == COMMIT_CNT)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (!res_n) begin
      DATA_L     <= '0;
      DATA_R     <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= (cnt == COMMIT_CNT);
      if (cnt == COMMIT_CNT) begin
        DATA_L <= bitNum'(saturate(64'(acc_l), bitNum));
        DATA_R <= bitNum'(saturate(64'(acc_r), bitNum));
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Randomized bench for i2s_frame_sequencer with a frame-schedule reference model and directed frames.
module tb_i2s_frame_sequencer;

  localparam int BN = 16;
  localparam int NS = 2;
  localparam int TO = 16;

  logic            MCLK = 1'b0;
  logic            res_n;
  logic            enable;
  logic [NS-1:0]   src_vld;
  logic [NS*BN-1:0] src_data_l;
  logic [NS*BN-1:0] src_data_r;
  logic [NS-1:0]   src_rdy;
  logic            SCLK;
  logic            LRCLK;
  logic [BN-1:0]   DATA_L;
  logic [BN-1:0]   DATA_R;
  logic [NS-1:0]   underrun;
  logic            frame_tick;

  i2s_frame_sequencer #(.bitNum(BN), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .MCLK       (MCLK),
    .res_n      (res_n),
    .enable     (enable),
    .src_vld    (src_vld),
    .src_data_l (src_data_l),
    .src_data_r (src_data_r),
    .src_rdy    (src_rdy),
    .SCLK       (SCLK),
    .LRCLK      (LRCLK),
    .DATA_L     (DATA_L),
    .DATA_R     (DATA_R),
    .underrun   (underrun),
    .frame_tick (frame_tick)
  );

  always #5 MCLK = ~MCLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  int          mcnt = 0;
  int          fr = 0;
  int          cyc = 0;
  bit          tick_exp = 1'b0;
  logic [NS-1:0] und_exp = '0;
  int          dl_exp = 0, dr_exp = 0;
  int          acc_l = 0, acc_r = 0;
  int          hold_l [NS];
  int          hold_r [NS];
  bit          p_en = 1'b0;
  int          p_d [NS];
  int          p_l [NS];
  int          p_r [NS];
  int          p_start [NS];
  int          p_len [NS];
  logic [NS-1:0] rdy_exp;
  logic [BN-1:0] e_l, e_r;
  logic [BN-1:0] lit;
  bit          rst_now;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cnt=%0d frame=%0d: got 0x%0h, expected 0x%0h", nm, mcnt, fr, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    int lim;
    lim = 1 << (BN - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic int rnd_val();
    logic signed [BN-1:0] t;
    case ($urandom_range(0, 3))
      0: return (1 << (BN - 1)) - 1;
      1: return -(1 << (BN - 1));
      default: begin
        t = BN'($urandom);
        return int'(t);
      end
    endcase
  endfunction

  task automatic make_plan(input int f);
    p_en = 1'b1;
    for (int i = 0; i < NS; i++) begin
      p_l[i] = rnd_val();
      p_r[i] = rnd_val();
      p_d[i] = $urandom_range(0, 3);
    end
    case (f)
      0: begin
        p_d[0] = 0; p_d[1] = 0;
        p_l[0] = 100; p_r[0] = -50; p_l[1] = 23; p_r[1] = 7;
      end
      1: begin
        p_d[0] = 2; p_d[1] = 5;
        p_l[0] = 'h7000; p_l[1] = 'h7000; p_r[0] = -'h7000; p_r[1] = -'h7000;
      end
      2: begin
        p_d[0] = 0; p_d[1] = TO + 4; p_l[0] = 5; p_r[0] = 0;
      end
      3: begin p_d[0] = TO - 1; p_d[1] = 0; end
      4: begin p_d[0] = TO + 1; p_d[1] = 0; end
      5: begin p_d[0] = 0; p_d[1] = 0; end
      default: begin
        p_en = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < NS; i++) begin
          case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: p_d[i] = $urandom_range(0, 3);
            6, 7:             p_d[i] = $urandom_range(4, TO + 3);
            default:          p_d[i] = $urandom_range(TO - 2, TO + 1);
          endcase
        end
      end
    endcase
    // Each source holds rdy until accept (d+1 cycles) or timeout (TO cycles), then one idle step.
    p_start[0] = 1;
    for (int i = 0; i < NS; i++) begin
      p_len[i] = (p_d[i] < TO) ? p_d[i] + 1 : TO;
      if (i + 1 < NS) p_start[i+1] = p_start[i] + p_len[i] + 1;
    end
  endtask

  initial begin
    res_n = 1'b0;
    enable = 1'b0;
    src_vld = '0;
    src_data_l = '0;
    src_data_r = '0;
    for (int i = 0; i < NS; i++) begin hold_l[i] = 0; hold_r[i] = 0; end

    while (fr < 32 || mcnt < 2) begin
      @(negedge MCLK);
      // Compare phase
      for (int i = 0; i < NS; i++)
        rdy_exp[i] = p_en && (mcnt >= p_start[i]) && (mcnt < p_start[i] + p_len[i]);
      e_l = dl_exp[BN-1:0];
      e_r = dr_exp[BN-1:0];
      chk("sclk", 32'(SCLK), 32'(mcnt[1]));
      chk("lrclk", 32'(LRCLK), 32'(mcnt[7]));
      chk("src_rdy", 32'(src_rdy), 32'(rdy_exp));
      chk("frame_tick", 32'(frame_tick), 32'(tick_exp));
      chk("data_l", 32'(DATA_L), 32'(e_l));
      chk("data_r", 32'(DATA_R), 32'(e_r));
      chk("underrun", 32'(underrun), 32'(und_exp));
      if (mcnt == 0) begin
        case (fr)
          1: begin
            chk("lit_sum_l", 32'(DATA_L), 32'h007B);
            chk("lit_sum_r", 32'(DATA_R), 32'hFFD5);
          end
          2: begin
            chk("lit_satpos", 32'(DATA_L), 32'h7FFF);
            chk("lit_satneg", 32'(DATA_R), 32'h8000);
          end
          3: begin
`ifdef UNDERRUN_HOLD_EN
            lit = 16'h7005;
`else
            lit = 16'h0005;
`endif
            chk("lit_timeout_l", 32'(DATA_L), 32'(lit));
            chk("lit_und_src1", 32'(underrun), 32'h2);
          end
          4: chk("lit_late_ok", 32'(underrun), 32'h2);
          5: chk("lit_late_to", 32'(underrun), 32'h3);
          6: begin
            chk("lit_rst_data", 32'(DATA_L), 32'h0);
            chk("lit_rst_und", 32'(underrun), 32'h0);
          end
          default: ;
        endcase
      end

      // Drive phase
      rst_now = (cyc < 5) || (fr == 6 && mcnt == 40);
      res_n = !rst_now;
      if (mcnt == 0 && !rst_now) begin
        make_plan(fr);
        fr++;
      end
      enable = (mcnt == 0) ? p_en : 1'($urandom);
      for (int i = 0; i < NS; i++) begin
        if (p_en && mcnt >= p_start[i] && mcnt < p_start[i] + p_len[i]) begin
          src_vld[i] = (mcnt - p_start[i] >= p_d[i]);
          if (mcnt - p_start[i] == p_d[i]) begin
            src_data_l[i*BN +: BN] = BN'(p_l[i]);
            src_data_r[i*BN +: BN] = BN'(p_r[i]);
          end else begin
            src_data_l[i*BN +: BN] = BN'($urandom);
            src_data_r[i*BN +: BN] = BN'($urandom);
          end
        end else begin
          src_vld[i] = 1'($urandom);
          src_data_l[i*BN +: BN] = BN'($urandom);
          src_data_r[i*BN +: BN] = BN'($urandom);
        end
      end

      @(posedge MCLK);
      // Model update for the edge just taken
      if (!res_n) begin
        mcnt = 0; p_en = 1'b0; und_exp = '0; dl_exp = 0; dr_exp = 0;
        tick_exp = 1'b0; acc_l = 0; acc_r = 0;
        for (int i = 0; i < NS; i++) begin hold_l[i] = 0; hold_r[i] = 0; end
      end else begin
        if (mcnt == 0) begin acc_l = 0; acc_r = 0; end
        if (p_en) begin
          for (int i = 0; i < NS; i++) begin
            if (mcnt == p_start[i] + p_len[i] - 1) begin
              if (p_d[i] < TO) begin
                acc_l += p_l[i]; acc_r += p_r[i];
                hold_l[i] = p_l[i]; hold_r[i] = p_r[i];
              end else begin
                und_exp[i] = 1'b1;
`ifdef UNDERRUN_HOLD_EN
                acc_l += hold_l[i]; acc_r += hold_r[i];
`endif
              end
            end
          end
        end
        tick_exp = (mcnt == 255);
        if (mcnt == 255) begin
          dl_exp = sat(acc_l);
          dr_exp = sat(acc_r);
        end
        mcnt = (mcnt + 1) % 256;
      end
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
